// File: rtl/inference_batch_controller.sv
// Fetches each image as multi-lane beats, streams them out, then scores the network's class result.
// First beat MEM_LATENCY+1 cycles after start; reads are credit-limited so a stalled pixel_ready never drops data.
module inference_batch_controller #(
    parameter int NUM_IMAGES  = 10000,
    parameter int NUM_PIXELS  = 784,
    parameter int PIXEL_WIDTH = 9,
    parameter int LANES       = 1,
    parameter int NUM_CLASSES = 10,
    parameter int MEM_LATENCY = 1,
    localparam int BEATS = NUM_PIXELS / LANES,
    localparam int CW    = $clog2(NUM_CLASSES),
    localparam int AW    = $clog2(NUM_IMAGES * BEATS),
    localparam int IW    = $clog2(NUM_IMAGES + 1),
    localparam int DW    = LANES * PIXEL_WIDTH
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          mode,
    input  logic          start,
    output logic          mem_read,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    input  logic [CW-1:0] label_data,
    output logic [DW-1:0] pixel_data,
    output logic          pixel_valid,
    input  logic          pixel_ready,
    output logic          pixel_last,
    input  logic          result_valid,
    input  logic [CW-1:0] result_class,
    output logic [IW-1:0] image_index,
    output logic [IW-1:0] correct_count,
    output logic          busy,
    output logic          output_ready,
    output logic          protocol_error
);
    localparam int DEPTH = MEM_LATENCY + 1;
    localparam int PTRW  = $clog2(DEPTH);
    localparam int CNTW  = $clog2(DEPTH + 1);
    localparam int BCW   = $clog2(BEATS + 1);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT_RESULT, DONE} state_t;

    state_t                 state;
    logic                   mode_r;
    logic [BCW-1:0]         issued;
    logic [AW-1:0]          addr;
    logic [CW-1:0]          label_r;
    logic [MEM_LATENCY-1:0] rd_vld, rd_first, rd_last;
    logic [DW:0]            fifo_mem [DEPTH];
    logic [PTRW-1:0]        wr_ptr, rd_ptr;
    logic [CNTW-1:0]        fifo_cnt, inflight;
    logic                   push, pop, read, credit_ok;

    function automatic logic [PTRW-1:0] ptr_next(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
    endfunction

    // A beat popped this cycle frees its slot, so steady streaming has no bubbles.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LATENCY; i++) inflight = inflight + CNTW'(rd_vld[i]);
        pop       = pixel_valid && pixel_ready;
        push      = rd_vld[MEM_LATENCY-1];
        credit_ok = ({1'b0, inflight} + {1'b0, fifo_cnt}) < ((CNTW+1)'(DEPTH) + (CNTW+1)'(pop));
        read      = (state == STREAM) && enable && (issued < BCW'(BEATS)) && credit_ok;
    end

    assign mem_read     = read;
    assign mem_addr     = addr;
    assign pixel_valid  = (fifo_cnt != '0);
    assign pixel_data   = pixel_valid ? fifo_mem[rd_ptr][DW-1:0] : '0;
    assign pixel_last   = pixel_valid ? fifo_mem[rd_ptr][DW] : 1'b0;
    assign busy         = (state == STREAM) || (state == WAIT_RESULT);
    assign output_ready = (state == DONE);

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= {rd_last[MEM_LATENCY-1], mem_data};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            mode_r         <= 1'b0;
            issued         <= '0;
            addr           <= '0;
            label_r        <= '0;
            rd_vld         <= '0;
            rd_first       <= '0;
            rd_last        <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_cnt       <= '0;
            image_index    <= '0;
            correct_count  <= '0;
            protocol_error <= 1'b0;
        end else begin
            rd_vld[0]   <= read;
            rd_first[0] <= (issued == '0);
            rd_last[0]  <= (issued == BCW'(BEATS - 1));
            for (int i = 1; i < MEM_LATENCY; i++) begin
                rd_vld[i]   <= rd_vld[i-1];
                rd_first[i] <= rd_first[i-1];
                rd_last[i]  <= rd_last[i-1];
            end

            if (read) begin
                issued <= issued + BCW'(1);
                addr   <= addr + AW'(1);
            end
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
                if (rd_first[MEM_LATENCY-1]) label_r <= label_data;
            end
            if (pop) rd_ptr <= ptr_next(rd_ptr);
            if (push && !pop)      fifo_cnt <= fifo_cnt + CNTW'(1);
            else if (!push && pop) fifo_cnt <= fifo_cnt - CNTW'(1);

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= STREAM;
                        mode_r         <= mode;
                        issued         <= '0;
                        addr           <= '0;
                        image_index    <= '0;
                        correct_count  <= '0;
                        protocol_error <= 1'b0;
                    end
                end
                STREAM: begin
                    if (pop && pixel_last) state <= WAIT_RESULT;
                end
                WAIT_RESULT: begin
                    if (result_valid) begin
                        if (result_class == label_r) correct_count <= correct_count + IW'(1);
                        // addr already points at the next image's first beat
                        if (mode_r && (int'(image_index) + 1 < NUM_IMAGES)) begin
                            image_index <= image_index + IW'(1);
                            issued      <= '0;
                            state       <= STREAM;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (result_valid && (state != WAIT_RESULT)) protocol_error <= 1'b1;
        end
    end
endmodule
